tr_sequencer: RTL and testbench

- Transmit/receive sequencer between the keying sources (host MOX / phone PTT, CW keyer) and the T/R resources: PA relays, PA bias, and RF transmit enable.
- Guarantees the order relays on -> settle -> RF on -> RF off -> tail -> relays off. Supports CW hang (relays held between characters) and a fault inhibit.
- Sits in radioberry_core beside the CW keyer. Its outputs drive io_pa_inttr, io_pa_exttr, io_pwr_envbias, io_cw_on and the TX datapath gate.

---
 rtl/tr_seq_pkg.sv | 18 +
 rtl/tr_sequencer_if.sv | 45 ++++
 rtl/tick_gen.sv | 43 ++++
 rtl/tr_sequencer.sv | 137 +++++++++++++
 tb/tb_tr_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/tr_seq_pkg.sv
// Shared definitions for the T/R sequencer: state codes and parameter defaults.
package tr_seq_pkg;

  // clk cycles per delay tick (1 ms at 76.8 MHz)
  localparam int unsigned TICK_DIV_DEF = 76800;
  // Width of the delay counter and the delay config fields
  localparam int unsigned CNT_W_DEF    = 10;

  // Codes are visible on tr_state for status readback; keep them fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_TX     = 3'd2,
    ST_HANG   = 3'd3,
    ST_TAIL   = 3'd4
  } tr_state_t;

endpackage : tr_seq_pkg

// File: rtl/tr_sequencer_if.sv
// Keying / config / T/R output bundle of the sequencer.
//   master : keying sources and config (drives requests, reads T/R outputs)
//   slave  : the sequencer itself
// Signals:
//   ptt_req, cw_key, tx_inhibit         keying requests and fault inhibit
//   cfg_pa_enable, cfg_ext_tr_enable    relay group enables
//   cfg_rf_delay, cfg_hang, cfg_tail    delays in ticks
//   tx_rf_on, cw_on                     RF / CW envelope gates
//   pa_inttr, pa_exttr, pa_bias_on      relay group
//   tr_state                            current state code
interface tr_sequencer_if
  import tr_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             ptt_req;
  logic             cw_key;
  logic             tx_inhibit;
  logic             cfg_pa_enable;
  logic             cfg_ext_tr_enable;
  logic [CNT_W-1:0] cfg_rf_delay;
  logic [CNT_W-1:0] cfg_hang;
  logic [CNT_W-1:0] cfg_tail;

  logic             tx_rf_on;
  logic             cw_on;
  logic             pa_inttr;
  logic             pa_exttr;
  logic             pa_bias_on;
  logic [2:0]       tr_state;

  modport master (
    output ptt_req, cw_key, tx_inhibit, cfg_pa_enable, cfg_ext_tr_enable,
           cfg_rf_delay, cfg_hang, cfg_tail,
    input  tx_rf_on, cw_on, pa_inttr, pa_exttr, pa_bias_on, tr_state
  );

  modport slave (
    input  ptt_req, cw_key, tx_inhibit, cfg_pa_enable, cfg_ext_tr_enable,
           cfg_rf_delay, cfg_hang, cfg_tail,
    output tx_rf_on, cw_on, pa_inttr, pa_exttr, pa_bias_on, tr_state
  );

endinterface : tr_sequencer_if

// File: rtl/tick_gen.sv
// Delay-tick prescaler. A restart clears the prescaler; a tick fires every
// TICK_DIV cycles after the last restart. TICK_DIV must be >= 2.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   restart_i   clears the prescaler on the next edge
//   tick_c_o    1-cycle tick (combinational from the prescaler register)
module tick_gen
  import tr_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_c_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;

  // Wrap at LAST, or restart from zero
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (restart_i || (presc_q == LAST)) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // A restart in the same cycle discards the stale tick
  assign tick_c_o = (presc_q == LAST) && !restart_i;

endmodule : tick_gen

// File: rtl/tr_sequencer.sv
// T/R sequencer: enforces relays on -> settle -> RF on -> RF off -> tail ->
// relays off, with CW hang between characters and a fault inhibit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        tr_sequencer_if.slave: keying inputs, config, T/R outputs
// All outputs are registered and change on the same edge as the state.
module tr_sequencer
  import tr_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  tr_sequencer_if.slave  bus
);

  tr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_cw_q, last_cw_d;
  logic             tx_rf_on_q, tx_rf_on_d;
  logic             cw_on_q, cw_on_d;
  logic             pa_inttr_q, pa_inttr_d;
  logic             pa_exttr_q, pa_exttr_d;
  logic             pa_bias_q, pa_bias_d;

  logic             req;
  logic             inh;
  logic             expired;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tick;

  assign req     = bus.ptt_req | bus.cw_key;
  assign inh     = bus.tx_inhibit;
  assign expired = (cnt_q == '0);

  // Prescaler restarts on every counter load
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .restart_i (load),
    .tick_c_o  (tick)
  );

  // Next state, counter and output decode
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    cnt_d    = cnt_q;

    // Last keyed source was CW alone; PTT together with CW counts as PTT
    last_cw_d = bus.cw_key & ~bus.ptt_req;

    case (state_q)
      ST_IDLE: begin
        if (req && !inh) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (inh || !req)  state_d = ST_TAIL;
        else if (expired) state_d = ST_TX;
      end
      ST_TX: begin
        if (inh) begin
          state_d = ST_TAIL;
        end else if (!req) begin
          if (last_cw_q && (bus.cfg_hang != '0)) state_d = ST_HANG;
          else                                   state_d = ST_TAIL;
        end
      end
      ST_HANG: begin
        if (inh)          state_d = ST_TAIL;
        else if (req)     state_d = ST_TX;
        else if (expired) state_d = ST_TAIL;
      end
      ST_TAIL: begin
        if (req && !inh)  state_d = ST_TX;
        else if (expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Timed states sample their delay only on entry
    if (state_d != state_q) begin
      case (state_d)
        ST_SETTLE: begin load = 1'b1; load_val = bus.cfg_rf_delay; end
        ST_HANG:   begin load = 1'b1; load_val = bus.cfg_hang;     end
        ST_TAIL:   begin load = 1'b1; load_val = bus.cfg_tail;     end
        default:   ;
      endcase
    end

    if (load) begin
      cnt_d = load_val;
    end else if (tick && !expired) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Outputs follow the next state so they land on the state edge
    tx_rf_on_d = (state_d == ST_TX);
    cw_on_d    = (state_d == ST_TX) & bus.cw_key;
    pa_inttr_d = bus.cfg_pa_enable     & (state_d != ST_IDLE);
    pa_bias_d  = bus.cfg_pa_enable     & (state_d != ST_IDLE);
    pa_exttr_d = bus.cfg_ext_tr_enable & (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_cw_q  <= 1'b0;
      tx_rf_on_q <= 1'b0;
      cw_on_q    <= 1'b0;
      pa_inttr_q <= 1'b0;
      pa_exttr_q <= 1'b0;
      pa_bias_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_cw_q  <= last_cw_d;
      tx_rf_on_q <= tx_rf_on_d;
      cw_on_q    <= cw_on_d;
      pa_inttr_q <= pa_inttr_d;
      pa_exttr_q <= pa_exttr_d;
      pa_bias_q  <= pa_bias_d;
    end
  end

  assign bus.tr_state   = state_q;
  assign bus.tx_rf_on   = tx_rf_on_q;
  assign bus.cw_on      = cw_on_q;
  assign bus.pa_inttr   = pa_inttr_q;
  assign bus.pa_exttr   = pa_exttr_q;
  assign bus.pa_bias_on = pa_bias_q;

endmodule : tr_sequencer

// File: tb/tb_tr_sequencer.sv
// Directed bench for tr_sequencer with TICK_DIV=10.
module tb_tr_sequencer;

  localparam int unsigned TDIV = 10;
  localparam int unsigned CW   = 10;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tr_sequencer_if #(.CNT_W(CW)) bus ();

  tr_sequencer #(.TICK_DIV(TDIV), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole output set: state, rf, cw, inttr, exttr, bias
  task automatic check_outs(input string tag, input int st, input bit rf,
                            input bit cwo, input bit it, input bit et,
                            input bit bi);
    check_eq({tag, ".state"}, 32'(bus.tr_state), 32'(st));
    check_eq({tag, ".rf"},    32'(bus.tx_rf_on), 32'(rf));
    check_eq({tag, ".cw"},    32'(bus.cw_on),    32'(cwo));
    check_eq({tag, ".inttr"}, 32'(bus.pa_inttr), 32'(it));
    check_eq({tag, ".exttr"}, 32'(bus.pa_exttr), 32'(et));
    check_eq({tag, ".bias"},  32'(bus.pa_bias_on), 32'(bi));
  endtask

  // Advance n active edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.ptt_req = 1'b0;
    bus.cw_key = 1'b0;
    bus.tx_inhibit = 1'b0;
    bus.cfg_pa_enable = 1'b1;
    bus.cfg_ext_tr_enable = 1'b0;
    bus.cfg_rf_delay = CW'(3);
    bus.cfg_hang = CW'(0);
    bus.cfg_tail = CW'(2);
    tick(3);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(2);
    check_outs("idle", 0, 0, 0, 0, 0, 0);

    // 1: PTT for 100 cycles, rf_delay=3, tail=2
    bus.ptt_req = 1'b1;
    tick(1);
    check_outs("s1.relay_on", 1, 0, 0, 1, 0, 1);
    tick(30);
    check_outs("s1.settle_end", 1, 0, 0, 1, 0, 1);
    tick(1);
    check_outs("s1.rf_on", 2, 1, 0, 1, 0, 1);
    tick(68);
    check_outs("s1.tx_hold", 2, 1, 0, 1, 0, 1);
    bus.ptt_req = 1'b0;
    tick(1);
    check_outs("s1.rf_off", 4, 0, 0, 1, 0, 1);
    tick(20);
    check_outs("s1.tail_end", 4, 0, 0, 1, 0, 1);
    tick(1);
    check_outs("s1.relay_off", 0, 0, 0, 0, 0, 0);

    // 2: CW with hang=5, ext T/R enabled
    bus.cfg_hang = CW'(5);
    bus.cfg_ext_tr_enable = 1'b1;
    bus.cw_key = 1'b1;
    tick(1);
    check_outs("s2.settle", 1, 0, 0, 1, 1, 1);
    tick(31);
    check_outs("s2.tx", 2, 1, 1, 1, 1, 1);
    tick(18);
    bus.cw_key = 1'b0;
    tick(1);
    check_outs("s2.hang", 3, 0, 0, 1, 1, 1);
    tick(29);
    check_outs("s2.hang_mid", 3, 0, 0, 1, 1, 1);
    bus.cw_key = 1'b1;
    tick(1);
    check_outs("s2.rekey_tx", 2, 1, 1, 1, 1, 1);
    tick(9);
    bus.cw_key = 1'b0;
    tick(1);
    check_outs("s2.hang2", 3, 0, 0, 1, 1, 1);
    tick(50);
    check_outs("s2.hang2_end", 3, 0, 0, 1, 1, 1);
    tick(1);
    check_outs("s2.tail", 4, 0, 0, 1, 1, 1);
    tick(20);
    check_eq("s2.tail_end.state", 32'(bus.tr_state), 32'd4);
    tick(1);
    check_outs("s2.idle", 0, 0, 0, 0, 0, 0);

    // 2b: PTT and CW released together count as PTT -> TAIL, not HANG
    bus.ptt_req = 1'b1;
    bus.cw_key = 1'b1;
    tick(32);
    check_outs("s2b.tx", 2, 1, 1, 1, 1, 1);
    bus.ptt_req = 1'b0;
    bus.cw_key = 1'b0;
    tick(1);
    check_outs("s2b.tail", 4, 0, 0, 1, 1, 1);
    tick(21);
    check_eq("s2b.idle.state", 32'(bus.tr_state), 32'd0);
    bus.cfg_ext_tr_enable = 1'b0;

    // 3: hang disabled, CW release goes straight to TAIL
    bus.cfg_hang = CW'(0);
    bus.cw_key = 1'b1;
    tick(32);
    check_outs("s3.tx", 2, 1, 1, 1, 0, 1);
    bus.cw_key = 1'b0;
    tick(1);
    check_outs("s3.tail", 4, 0, 0, 1, 0, 1);
    tick(21);
    check_eq("s3.idle.state", 32'(bus.tr_state), 32'd0);

    // 4: inhibit in TX, req held
    bus.ptt_req = 1'b1;
    tick(32);
    check_eq("s4.tx.state", 32'(bus.tr_state), 32'd2);
    bus.tx_inhibit = 1'b1;
    tick(1);
    check_outs("s4.inhibit", 4, 0, 0, 1, 0, 1);
    tick(20);
    check_eq("s4.tail_hold.state", 32'(bus.tr_state), 32'd4);
    tick(1);
    check_outs("s4.idle", 0, 0, 0, 0, 0, 0);
    tick(5);
    check_outs("s4.no_reentry", 0, 0, 0, 0, 0, 0);
    bus.tx_inhibit = 1'b0;
    bus.ptt_req = 1'b0;
    tick(2);

    // 5: rf_delay=0 -> single-cycle SETTLE; req during TAIL -> TX
    bus.cfg_rf_delay = CW'(0);
    bus.ptt_req = 1'b1;
    tick(1);
    check_outs("s5.settle", 1, 0, 0, 1, 0, 1);
    tick(1);
    check_outs("s5.tx", 2, 1, 0, 1, 0, 1);
    bus.ptt_req = 1'b0;
    tick(1);
    check_eq("s5.tail.state", 32'(bus.tr_state), 32'd4);
    tick(5);
    bus.ptt_req = 1'b1;
    tick(1);
    check_outs("s5.tail_to_tx", 2, 1, 0, 1, 0, 1);

    // 6: reset while in TX
    rst = 1'b1;
    tick(1);
    check_outs("s6.reset", 0, 0, 0, 0, 0, 0);
    bus.ptt_req = 1'b0;
    rst = 1'b0;
    tick(2);
    check_outs("s6.after", 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tr_sequencer
